// File: rtl/button_event_gen.sv
// Turns the debounced button level into press, release, long-press hold and
// auto-repeat events, all registered and one clock wide (hold is a level).
module button_event_gen #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold,
    output logic repeat_pulse,
    output logic step_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HOLDING
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    generate
        if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
            $error("button_event_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             clean_q;
    logic             press_next;
    logic             release_next;
    logic             hold_next;
    logic             repeat_next;

    // Release is tested before the threshold so it always wins a tie.
    always_comb begin
        state_next   = state;
        count_next   = count;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                if (clean && !clean_q) begin
                    press_next = 1'b1;
                    state_next = PRESSED;
                    count_next = '0;
                end
            end
            PRESSED: begin
                if (!clean) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    count_next   = '0;
                end else if (count == HOLD_LAST) begin
                    repeat_next = 1'b1;
                    state_next  = HOLDING;
                    count_next  = '0;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            HOLDING: begin
                if (!clean) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    count_next   = '0;
                end else if (count == REPEAT_LAST) begin
                    repeat_next = 1'b1;
                    count_next  = '0;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
        hold_next = (state_next == HOLDING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            clean_q       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            clean_q       <= clean;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            hold          <= hold_next;
            repeat_pulse  <= repeat_next;
            step_pulse    <= press_next | repeat_next;
        end
    end

endmodule
